ibuffer: RTL and testbench
==========================

# ibuffer

Instruction buffer between fetch and decode.
- Accepts fetch groups of up to two 32-bit instructions per cycle and queues them in program order.
- Presents one instruction per cycle, with its PC, to the decoder on the `ibuffer_*` interface.
- Applies backpressure toward fetch and discards all contents on a pipeline flush.

## Interface
Parameters:
- `DEPTH`, 8: number of instruction entries; a power of two, at least 4.

Ports:
- `clock`  input  1  single clock domain for the block.
- `reset_n`  input  1  reset; synchronous and active-low.
- `fetch_valid`  input  1  a fetch group is offered this cycle.
- `fetch_ready`  output  1  buffer can accept a group; high iff free entries ≥ 2.
- `fetch_inst`  input  64  [31:0] is the instruction at `fetch_pc`; [63:32] is the instruction at `fetch_pc`+4.
- `fetch_pc`  input  `PC_RANGE  PC of slot 0, 4-byte aligned.
- `fetch_mask`  input  2  bit i set means slot i holds a valid instruction.
- `flush`  input  1  redirect from the backend; discards all entries.
- `decode_ready`  input  1  decoder consumes the head instruction this cycle.
- `ibuffer_instr_valid`  output  1  head entry is valid.
- `ibuffer_inst_out`  output  32  head instruction.
- `ibuffer_pc_out`  output  `PC_RANGE  head PC.
- `ibuffer_count`  output  $clog2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a circular array of DEPTH entries {inst[31:0], pc}. It uses head and tail pointers of width $clog2(DEPTH), plus an occupancy counter `count`.
- Full/empty is determined by `count` only: count==0 is empty, count==DEPTH is full. Pointers wrap modulo DEPTH.
- Enqueue fires when `fetch_valid && fetch_ready && !flush`.
  - Valid slots are compacted and written in order: slot 0 at tail, then slot 1 at tail+1 if both are valid.
  - Slot 1's stored PC is `fetch_pc`+4.
  - n_enq = popcount(`fetch_mask`). Mask 2'b00 is accepted and has no effect. Mask 2'b10 writes only the slot-1 instruction, with pc = `fetch_pc`+4.
  - tail advances by n_enq.
- Dequeue fires when `ibuffer_instr_valid && decode_ready && !flush`; head advances by 1.
- Simultaneous enqueue and dequeue: count_next = count + n_enq − deq. A full-minus-two buffer with a dequeue therefore still accepts 2.
- `fetch_ready` = (DEPTH − count ≥ 2), computed from the registered count only. A same-cycle dequeue never raises it, which keeps the decoder-to-fetch path free of combinational logic.
- `flush` has top priority. On the next edge count=0 and head=tail=0. The same-cycle enqueue and dequeue are both dropped.
- Head outputs are read combinationally from storage at head:
  - `ibuffer_instr_valid` = (count != 0).
  - When empty, `ibuffer_inst_out` and `ibuffer_pc_out` are driven to 0.
- Storage data itself is not reset; only pointers and count are.

## Timing
- Reset: while `reset_n` is low at a rising edge, count, head and tail are set to 0. After that edge `ibuffer_instr_valid`=0, `ibuffer_inst_out`=0, `ibuffer_pc_out`=0, `ibuffer_count`=0, `fetch_ready`=1.
- Reset asserted mid-operation behaves identically to flush: all entries are lost, with no partial drain.
- Enqueue-to-output latency is 1 cycle. There is no bypass, so an instruction written at edge N is visible on the `ibuffer_*` outputs after edge N.
- Throughput: up to 2 enqueued and 1 dequeued per cycle.
- Stall rule: while `ibuffer_instr_valid && !decode_ready`, the head outputs stay stable until accepted or flushed.
- `fetch_ready` does not depend on `fetch_valid`. Fetch must hold its group while `fetch_ready` is low.
- A flush in cycle N means `ibuffer_instr_valid`=0 in cycle N+1. A group offered in N+1 with `fetch_ready`=1 is accepted normally.

## Structure
- `PC_RANGE` comes from the shared defines header.
- Define a `IBUF_ENTRY` width constant (32 + PC width) in the shared backend package.
- No sub-module. Pointer, counter and storage logic live in `ibuffer` itself; expected size is about 150–250 lines.
- Storage is a flop array. Write ports are indexed by tail and tail+1, and the read port is indexed by head.

## Test plan
- Reset, then fetch {mask=2'b11, pc=0x8000_0000, inst=0x0000_0513_0000_0093} -> next cycle: valid=1, inst=0x00000093, pc=0x8000_0000. With `decode_ready`=1: next cycle inst=0x00000513, pc=0x8000_0004, then valid=0.
- mask=2'b10, pc=0x1000 -> exactly one entry with pc=0x1004 and inst=`fetch_inst`[63:32]; count=1.
- DEPTH=8, `decode_ready`=0, back-to-back groups with mask 2'b11 -> count reaches 8 after 4 accepts. `fetch_ready` drops when count=7 or 8, and the head is unchanged throughout.
- Wrap-around: stream 20 sequential instructions with `decode_ready` toggling 1/0 -> all 20 emerge in order with correct PCs, none lost or duplicated.
- count=5 with `flush`=1, `fetch_valid`=1 and `decode_ready`=1 in the same cycle -> next cycle count=0 and valid=0; the group offered during the flush is never output.
- `reset_n` low for 1 cycle while count=6 -> all outputs return to their reset values, then normal operation resumes.

Source files
------------

// File: rtl/ibuffer_pkg.sv
// ibuffer_pkg: shared backend definitions used by the instruction buffer.
//   PC_RANGE   - macro giving the PC bit range (shared defines)
//   PC_W       - PC width derived from PC_RANGE
//   IBUF_ENTRY - width of one stored entry {inst, pc}
//   ibuf_entry_t - packed storage entry
`ifndef PC_RANGE
`define PC_RANGE 31:0
`endif

package ibuffer_pkg;

    localparam int PC_W       = $bits(logic [`PC_RANGE]);
    localparam int INST_W     = 32;
    localparam int IBUF_ENTRY = INST_W + PC_W;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } ibuf_entry_t;

endpackage

// File: rtl/ibuffer.sv
// ibuffer: instruction queue between fetch and decode.
// Accepts up to two instructions per cycle (compacted, program order) and
// presents the oldest one with its PC to decode. Flush/reset drop everything.
// Ports:
//   clock, reset_n                 - clock, synchronous active-low reset
//   fetch_valid/ready/inst/pc/mask - fetch group handshake (2 slots)
//   flush                          - discard all entries, top priority
//   decode_ready                   - decoder consumes head this cycle
//   ibuffer_instr_valid/inst_out/pc_out - head entry (zero when empty)
//   ibuffer_count                  - occupied entries
`ifndef PC_RANGE
`define PC_RANGE 31:0
`endif

module ibuffer
    import ibuffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       fetch_valid,
    output logic                       fetch_ready,
    input  logic [63:0]                fetch_inst,
    input  logic [`PC_RANGE]           fetch_pc,
    input  logic [1:0]                 fetch_mask,
    input  logic                       flush,
    input  logic                       decode_ready,
    output logic                       ibuffer_instr_valid,
    output logic [31:0]                ibuffer_inst_out,
    output logic [`PC_RANGE]           ibuffer_pc_out,
    output logic [$clog2(DEPTH):0]     ibuffer_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    ibuf_entry_t   mem_q [DEPTH];
    ibuf_entry_t   mem_d [DEPTH];

    logic          enq, deq;
    logic [CW-1:0] n_enq;
    ibuf_entry_t   slot0_e, slot1_e, first_e;

    // Ready comes from registered count only so decode_ready never
    // reaches fetch_ready combinationally.
    assign fetch_ready = (count_q <= CW'(DEPTH - 2));

    assign ibuffer_instr_valid = (count_q != '0);
    assign ibuffer_count       = count_q;
    assign ibuffer_inst_out    = ibuffer_instr_valid ? mem_q[head_q].inst : '0;
    assign ibuffer_pc_out      = ibuffer_instr_valid ? mem_q[head_q].pc   : '0;

    always_comb begin
        enq     = fetch_valid && fetch_ready && !flush;
        deq     = ibuffer_instr_valid && decode_ready && !flush;
        n_enq   = CW'(fetch_mask[0]) + CW'(fetch_mask[1]);

        slot0_e = '{inst: fetch_inst[31:0],  pc: fetch_pc};
        slot1_e = '{inst: fetch_inst[63:32], pc: fetch_pc + PC_W'(4)};
        // Compaction: the first valid slot always lands at tail.
        first_e = fetch_mask[0] ? slot0_e : slot1_e;

        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq && (fetch_mask != 2'b00))
                mem_d[tail_q] = first_e;
            if (enq && (fetch_mask == 2'b11))
                mem_d[tail_q + AW'(1)] = slot1_e;
            if (enq)
                tail_d = tail_q + n_enq[AW-1:0];
            if (deq)
                head_d = head_q + AW'(1);
            count_d = count_q + (enq ? n_enq : '0) - CW'(deq);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage data is intentionally not reset; count gates its visibility.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_ibuffer.sv
`ifndef PC_RANGE
`define PC_RANGE 31:0
`endif

module tb_ibuffer;

    localparam int DEPTH = 8;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   fetch_valid;
    logic                   fetch_ready;
    logic [63:0]            fetch_inst;
    logic [`PC_RANGE]       fetch_pc;
    logic [1:0]             fetch_mask;
    logic                   flush;
    logic                   decode_ready;
    logic                   ibuffer_instr_valid;
    logic [31:0]            ibuffer_inst_out;
    logic [`PC_RANGE]       ibuffer_pc_out;
    logic [$clog2(DEPTH):0] ibuffer_count;

    int n_cmp = 0;
    int n_bad = 0;

    ibuffer #(.DEPTH(DEPTH)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .fetch_valid         (fetch_valid),
        .fetch_ready         (fetch_ready),
        .fetch_inst          (fetch_inst),
        .fetch_pc            (fetch_pc),
        .fetch_mask          (fetch_mask),
        .flush               (flush),
        .decode_ready        (decode_ready),
        .ibuffer_instr_valid (ibuffer_instr_valid),
        .ibuffer_inst_out    (ibuffer_inst_out),
        .ibuffer_pc_out      (ibuffer_pc_out),
        .ibuffer_count       (ibuffer_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] m, input logic [31:0] pc, input logic [63:0] inst);
        fetch_valid = 1'b1;
        fetch_mask  = m;
        fetch_pc    = pc;
        fetch_inst  = inst;
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, 64'(ibuffer_instr_valid), 64'd0);
        chk({tag, "_inst"},  64'(ibuffer_inst_out),    64'd0);
        chk({tag, "_pc"},    64'(ibuffer_pc_out),      64'd0);
        chk({tag, "_count"}, 64'(ibuffer_count),       64'd0);
        chk({tag, "_ready"}, 64'(fetch_ready),         64'd1);
    endtask

    initial begin
        reset_n      = 1'b0;
        fetch_valid  = 1'b0;
        fetch_inst   = '0;
        fetch_pc     = '0;
        fetch_mask   = 2'b00;
        flush        = 1'b0;
        decode_ready = 1'b0;

        // Reset
        step();
        step();
        chk_reset_state("rst");
        reset_n = 1'b1;

        // Basic pair, then drain
        push(2'b11, 32'h8000_0000, 64'h0000_0513_0000_0093);
        chk("t1_valid", 64'(ibuffer_instr_valid), 64'd1);
        chk("t1_inst0", 64'(ibuffer_inst_out), 64'h0000_0093);
        chk("t1_pc0",   64'(ibuffer_pc_out),   64'h8000_0000);
        chk("t1_count", 64'(ibuffer_count),    64'd2);
        decode_ready = 1'b1;
        step();
        chk("t1_inst1", 64'(ibuffer_inst_out), 64'h0000_0513);
        chk("t1_pc1",   64'(ibuffer_pc_out),   64'h8000_0004);
        step();
        chk("t1_empty", 64'(ibuffer_instr_valid), 64'd0);
        decode_ready = 1'b0;

        // Slot-1-only group
        push(2'b10, 32'h0000_1000, 64'hAAAA_0001_BBBB_0002);
        chk("t2_count", 64'(ibuffer_count),    64'd1);
        chk("t2_inst",  64'(ibuffer_inst_out), 64'hAAAA_0001);
        chk("t2_pc",    64'(ibuffer_pc_out),   64'h0000_1004);
        decode_ready = 1'b1;
        step();
        decode_ready = 1'b0;
        chk("t2_drain", 64'(ibuffer_count), 64'd0);

        // Mask 00 accepted with no effect
        push(2'b00, 32'h0000_3000, 64'h1111_1111_2222_2222);
        chk("t2_m00", 64'(ibuffer_count), 64'd0);

        // Fill to full with decode stalled
        for (int k = 0; k < 4; k++) begin
            chk("fill_ready_pre", 64'(fetch_ready), 64'd1);
            push(2'b11, 32'h2000 + 32'(8 * k), {32'h2000_0001 + 32'(2 * k), 32'h2000_0000 + 32'(2 * k)});
            chk("fill_count", 64'(ibuffer_count), 64'(2 * (k + 1)));
            chk("fill_head",  64'(ibuffer_pc_out), 64'h2000);
            chk("fill_ready", 64'(fetch_ready), (k < 3) ? 64'd1 : 64'd0);
        end
        // Full: offer is refused while one dequeues
        decode_ready = 1'b1;
        push(2'b11, 32'h6000, 64'hDEAD_0001_DEAD_0000);
        chk("full_count7", 64'(ibuffer_count),  64'd7);
        chk("full_ready7", 64'(fetch_ready),    64'd0);
        chk("full_head7",  64'(ibuffer_pc_out), 64'h2004);
        decode_ready = 1'b0;
        push(2'b11, 32'h6000, 64'hDEAD_0001_DEAD_0000);
        chk("hold_count7", 64'(ibuffer_count),  64'd7);
        chk("hold_head7",  64'(ibuffer_pc_out), 64'h2004);
        decode_ready = 1'b1;
        push(2'b11, 32'h6000, 64'hDEAD_0001_DEAD_0000);
        chk("deq_count6", 64'(ibuffer_count), 64'd6);
        chk("deq_ready6", 64'(fetch_ready),   64'd1);
        // Full-minus-two with a dequeue still accepts both
        push(2'b11, 32'h2020, 64'h2000_0009_2000_0008);
        chk("fm2_count", 64'(ibuffer_count),  64'd7);
        chk("fm2_head",  64'(ibuffer_pc_out), 64'h200C);
        decode_ready = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fill_flush", 64'(ibuffer_count), 64'd0);

        // Wrap-around stream of 20 instructions
        begin
            int  g    = 0;
            int  nout = 0;
            bit  acc;
            for (int cyc = 0; cyc < 200 && nout < 20; cyc++) begin
                decode_ready = cyc[0];
                if (g < 10) begin
                    fetch_valid = 1'b1;
                    fetch_mask  = 2'b11;
                    fetch_pc    = 32'h4000 + 32'(8 * g);
                    fetch_inst  = {32'hC000_0000 + 32'(2 * g + 1), 32'hC000_0000 + 32'(2 * g)};
                end else begin
                    fetch_valid = 1'b0;
                end
                #1;
                if (ibuffer_instr_valid && decode_ready) begin
                    chk("wrap", {ibuffer_inst_out, ibuffer_pc_out},
                        {32'hC000_0000 + 32'(nout), 32'h4000 + 32'(4 * nout)});
                    nout++;
                end
                acc = fetch_valid && fetch_ready;
                step();
                if (acc) g++;
            end
            fetch_valid  = 1'b0;
            decode_ready = 1'b0;
            chk("wrap_n", 64'(nout), 64'd20);
            chk("wrap_empty", 64'(ibuffer_count), 64'd0);
        end

        // Flush at count 5 with concurrent enqueue and dequeue
        push(2'b11, 32'h5000, 64'h5000_0001_5000_0000);
        push(2'b11, 32'h5008, 64'h5000_0003_5000_0002);
        push(2'b01, 32'h5010, 64'h5000_0005_5000_0004);
        chk("fl_count5", 64'(ibuffer_count), 64'd5);
        flush        = 1'b1;
        decode_ready = 1'b1;
        push(2'b11, 32'hD000, 64'hDEAD_BEEF_DEAD_BEEE);
        flush        = 1'b0;
        decode_ready = 1'b0;
        chk("fl_count", 64'(ibuffer_count),       64'd0);
        chk("fl_valid", 64'(ibuffer_instr_valid), 64'd0);
        step();
        chk("fl_stay", 64'(ibuffer_count), 64'd0);
        push(2'b01, 32'h7000, 64'h0000_0000_7777_0000);
        chk("fl_after_inst", 64'(ibuffer_inst_out), 64'h7777_0000);
        chk("fl_after_pc",   64'(ibuffer_pc_out),   64'h7000);
        chk("fl_after_cnt",  64'(ibuffer_count),    64'd1);
        decode_ready = 1'b1;
        step();
        decode_ready = 1'b0;

        // Reset mid-operation at count 6
        push(2'b11, 32'h8000, 64'h8000_0001_8000_0000);
        push(2'b11, 32'h8008, 64'h8000_0003_8000_0002);
        push(2'b11, 32'h8010, 64'h8000_0005_8000_0004);
        chk("mr_count6", 64'(ibuffer_count), 64'd6);
        reset_n = 1'b0;
        step();
        chk_reset_state("mr");
        reset_n = 1'b1;
        push(2'b01, 32'h9000, 64'h0000_0000_1234_5678);
        chk("mr_resume_inst", 64'(ibuffer_inst_out), 64'h1234_5678);
        chk("mr_resume_pc",   64'(ibuffer_pc_out),   64'h9000);
        chk("mr_resume_cnt",  64'(ibuffer_count),    64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
